// File: rtl/pokey_pkg.sv
// pokey_pkg: shared SKCTL bit indices, reset value and serial clock mode encoding
package pokey_pkg;

    localparam int SK_DEBOUNCE   = 0;
    localparam int SK_SCAN       = 1;
    localparam int SK_FASTPOT    = 2;
    localparam int SK_TWOTONE    = 3;
    localparam int SK_SERMODE_LO = 4;
    localparam int SK_SERMODE_HI = 6;
    localparam int SK_BREAK      = 7;

    localparam logic [7:0] SKCTL_RESET = 8'h00;

    typedef enum logic [2:0] {
        SER_MODE_0 = 3'd0,
        SER_MODE_1 = 3'd1,
        SER_MODE_2 = 3'd2,
        SER_MODE_3 = 3'd3,
        SER_MODE_4 = 3'd4,
        SER_MODE_5 = 3'd5,
        SER_MODE_6 = 3'd6,
        SER_MODE_7 = 3'd7
    } ser_mode_t;

endpackage

// File: rtl/skctls_reg.sv
// skctls_reg: POKEY SKCTL write register with init-state decode; SKCTLS_DECODE_EN adds per-field outputs
module skctls_reg
    import pokey_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = SKCTL_RESET
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enn,
    input  logic       wren,
    input  logic [7:0] d,
    output logic [7:0] skctls,
`ifdef SKCTLS_DECODE_EN
    output logic       kbd_debounce,
    output logic       kbd_scan,
    output logic       fast_pot,
    output logic       two_tone,
    output logic [2:0] ser_mode,
    output logic       force_break,
`endif
    output logic       init
);

    logic [7:0] r_skctls;
    logic       w_load;

    assign w_load = enn & wren;

    // Load the CPU byte only on the phi2 negative-edge strobe; reset wins over any write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_skctls <= RESET_VAL;
        else if (w_load) r_skctls <= d;
    end

    assign skctls = r_skctls;
    assign init   = ~(r_skctls[SK_SCAN] | r_skctls[SK_DEBOUNCE]);

`ifdef SKCTLS_DECODE_EN
    assign kbd_debounce = r_skctls[SK_DEBOUNCE];
    assign kbd_scan     = r_skctls[SK_SCAN];
    assign fast_pot     = r_skctls[SK_FASTPOT];
    assign two_tone     = r_skctls[SK_TWOTONE];
    assign ser_mode     = r_skctls[SK_SERMODE_HI:SK_SERMODE_LO];
    assign force_break  = r_skctls[SK_BREAK];
`endif

endmodule

// File: tb/tb_skctls_reg.sv
// tb_skctls_reg: directed self-checking bench for the SKCTL write register
module tb_skctls_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enn = 1'b0;
    logic       wren = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] skctls;
    logic       init;
`ifdef SKCTLS_DECODE_EN
    logic       kbd_debounce, kbd_scan, fast_pot, two_tone, force_break;
    logic [2:0] ser_mode;
`endif

    int tests = 0;
    int fails = 0;

    skctls_reg dut (
        .clk(clk),
        .rst_n(rst_n),
        .enn(enn),
        .wren(wren),
        .d(d),
        .skctls(skctls),
`ifdef SKCTLS_DECODE_EN
        .kbd_debounce(kbd_debounce),
        .kbd_scan(kbd_scan),
        .fast_pot(fast_pot),
        .two_tone(two_tone),
        .ser_mode(ser_mode),
        .force_break(force_break),
`endif
        .init(init)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] v);
        @(negedge clk);
        d = v;
        wren = 1'b1;
        enn = 1'b1;
        @(posedge clk);
        #1;
        enn = 1'b0;
        wren = 1'b0;
    endtask

    initial begin
        // 1: asynchronous reset without a clock edge
        wr(8'hA7);
        chk("pre_reset_val", skctls, 8'hA7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_skctls", skctls, 8'h00);
        chk("async_rst_init", {7'd0, init}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        // 2: single load, with one-edge latency
        @(negedge clk);
        d = 8'hF1;
        wren = 1'b1;
        enn = 1'b1;
        #1;
        chk("before_edge", skctls, 8'h00);
        @(posedge clk);
        #1;
        enn = 1'b0;
        wren = 1'b0;
        chk("load_f1", skctls, 8'hF1);
        chk("init_f1", {7'd0, init}, 8'h00);
        // 3
        wr(8'h00);
        chk("init_00", {7'd0, init}, 8'h01);
        wr(8'h03);
        chk("load_03", skctls, 8'h03);
        chk("init_03", {7'd0, init}, 8'h00);
        // 4
        wr(8'hFE);
        chk("init_fe", {7'd0, init}, 8'h00);
        wr(8'hFC);
        chk("load_fc", skctls, 8'hFC);
        chk("init_fc", {7'd0, init}, 8'h01);
        // 5: wren without enn holds, then loads on the next strobe
        @(negedge clk);
        d = 8'h55;
        wren = 1'b1;
        repeat (6) @(negedge clk);
        chk("wren_no_enn", skctls, 8'hFC);
        enn = 1'b1;
        @(negedge clk);
        enn = 1'b0;
        chk("enn_after_wren", skctls, 8'h55);
        // wren still high: changing d without enn must not reload
        d = 8'hBB;
        repeat (4) @(negedge clk);
        chk("one_load_per_enn", skctls, 8'h55);
        wren = 1'b0;
        // enn without wren holds
        d = 8'h77;
        enn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        enn = 1'b0;
        chk("enn_no_wren", skctls, 8'h55);
        chk("init_55", {7'd0, init}, 8'h00);
`ifdef SKCTLS_DECODE_EN
        wr(8'hA6);
        chk("dec_fields", {force_break, ser_mode, two_tone, fast_pot, kbd_scan, kbd_debounce}, 8'hA6);
`endif
        // 6: reset coincident with a write of FF: reset wins
        @(negedge clk);
        d = 8'hFF;
        wren = 1'b1;
        enn = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vs_write", skctls, 8'h00);
        chk("rst_vs_write_init", {7'd0, init}, 8'h01);
        @(negedge clk);
        enn = 1'b0;
        wren = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_hold", skctls, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
